aes128_enc_sequencer: RTL

- Iterative AES-128 encryption controller. It time-shares one external round datapath (SubBytes → ShiftRows → [MixColumns] → AddRoundKey) across all 10 rounds.
- Accepts plaintext and key on a valid/ready input, performs the initial AddRoundKey and on-the-fly key expansion internally, and issues one round at a time.
- Returns ciphertext on a valid/ready output.
- Sits between the block-level host interface and the shared round datapath, replacing the unrolled round_1..round_10 chain where area matters.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_key_expand_step.sv | 38 +++
 rtl/aes128_enc_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 definitions for the iterative encryption sequencer and the
//   external round datapath.
//   Contents:
//     state_e      - sequencer FSM encoding (IDLE, ISSUE, WAIT, DONE)
//     NUM_ROUNDS   - round count for AES-128
//     rcon()       - round constant for rounds 1..10 (0 elsewhere)
//     sbox()       - forward S-box byte substitution, shared with sub_bytes
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'h00;
    m   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ m;
      m = xtime(m);
    end
    return acc;
  endfunction

  // S-box = affine(x^254). x^254 is the multiplicative inverse (and maps 0 to
  // 0), built as x^2 * x^4 * ... * x^128 by repeated squaring.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// -----------------------------------------------------------------------------
// aes_key_expand_step
//   One step of the AES-128 key schedule (purely combinational):
//     w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}
//     w1' = w1 ^ w0';  w2' = w2 ^ w1';  w3' = w3 ^ w2'
//   Ports:
//     key_in  [127:0] - previous round key, w0 in bits [127:96]
//     rcon    [7:0]   - round constant for the round being produced
//     key_out [127:0] - next round key
// -----------------------------------------------------------------------------
module aes_key_expand_step (
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_sequencer.sv
// -----------------------------------------------------------------------------
// aes128_enc_sequencer
//   Iterative AES-128 encryption controller. Performs the initial AddRoundKey
//   and on-the-fly key expansion, then issues the ten rounds one at a time to
//   a shared external round datapath (SubBytes, ShiftRows, [MixColumns],
//   AddRoundKey) whose result appears ROUND_LAT cycles after rnd_start.
//
//   Parameters:
//     BLOCK_LENGTH - state/key width, 128 only
//     ROUND_LAT    - cycles from rnd_start to valid rnd_out, 1..7
//     NUM_ROUNDS   - 10 for AES-128
//
//   Ports:
//     clk, rst            - clock; synchronous active-low reset
//     in_valid/in_ready   - plaintext/key handshake (in_pt, in_key)
//     rnd_start           - one-cycle pulse, round datapath begins a round
//     rnd_state, rnd_key  - round datapath operands, held through the round
//     rnd_final           - round 10: datapath bypasses MixColumns
//     rnd_out             - round datapath result, sampled once per round
//     out_valid/out_ready - ciphertext handshake (out_ct)
//     busy                - sequencer not in IDLE
//     round_cnt           - current round, 0 in IDLE
//
//   Build option:
//     AES_BACK2BACK_EN - when defined, a new block may be accepted on the same
//                        edge that completes the ciphertext transfer.
// -----------------------------------------------------------------------------
module aes128_enc_sequencer #(
  parameter int BLOCK_LENGTH = 128,
  parameter int ROUND_LAT    = 2,
  parameter int NUM_ROUNDS   = aes_pkg::NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_pt,
  input  logic [BLOCK_LENGTH-1:0] in_key,
  output logic                    rnd_start,
  output logic [BLOCK_LENGTH-1:0] rnd_state,
  output logic [BLOCK_LENGTH-1:0] rnd_key,
  output logic                    rnd_final,
  input  logic [BLOCK_LENGTH-1:0] rnd_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_ct,
  output logic                    busy,
  output logic [3:0]              round_cnt
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [2:0] WAIT_LOAD  = 3'(ROUND_LAT);

  state_e                    state_q, state_d;
  logic [3:0]                round_q, round_d;
  logic [2:0]                wait_q,  wait_d;
  logic [BLOCK_LENGTH-1:0]   data_q,  data_d;
  logic [BLOCK_LENGTH-1:0]   key_q,   key_d;
  logic [BLOCK_LENGTH-1:0]   ct_q,    ct_d;
  logic [BLOCK_LENGTH-1:0]   key_next;
  logic                      accept;

  // Round key for round_q, derived from the previous round key held in key_q.
  aes_key_expand_step u_key_step (
    .key_in  (key_q),
    .rcon    (rcon(round_q)),
    .key_out (key_next)
  );

`ifdef AES_BACK2BACK_EN
  assign in_ready = rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
`else
  assign in_ready = rst & (state_q == IDLE);
`endif

  assign accept = in_valid & in_ready;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wait_d  = wait_q;
    data_d  = data_q;
    key_d   = key_q;
    ct_d    = ct_q;

    case (state_q)
      IDLE: ;
      ISSUE: begin
        key_d   = key_next;
        wait_d  = WAIT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // The datapath result is valid only in the last WAIT cycle.
        if (wait_q == 3'd1) begin
          data_d = rnd_out;
          if (round_q == LAST_ROUND) begin
            ct_d    = rnd_out;
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          round_d = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Takes priority over the DONE exit so a back-to-back accept goes
    // straight to ISSUE without passing through IDLE.
    if (accept) begin
      data_d  = in_pt ^ in_key;
      key_d   = in_key;
      round_d = 4'd1;
      state_d = ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  // NOTE: reset is synchronous; the data registers are cleared too so that
  // rnd_state, rnd_key and out_ct read as zero while rst is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      wait_q  <= 3'd0;
      data_q  <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  // In ISSUE the fresh round key is presented combinationally; from WAIT on it
  // has been registered into key_q, so the value stays stable for the round.
  assign rnd_start = (state_q == ISSUE);
  assign rnd_state = data_q;
  assign rnd_key   = (state_q == ISSUE) ? key_next : key_q;
  assign rnd_final = ((state_q == ISSUE) || (state_q == WAIT)) && (round_q == LAST_ROUND);
  assign out_valid = (state_q == DONE);
  assign out_ct    = ct_q;
  assign busy      = (state_q != IDLE);
  assign round_cnt = round_q;

endmodule
